// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm arming controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alarm_pkg;

  typedef enum logic [2:0] {
    DISARMED    = 3'd0,
    EXIT_DELAY  = 3'd1,
    ARMED       = 3'd2,
    ENTRY_DELAY = 3'd3,
    ALARM       = 3'd4
  } state_t;

  localparam int          CODE_W          = 6;
  localparam logic [5:0]  ARM_CODE_DEF    = 6'b011111;
  localparam logic [5:0]  DISARM_CODE_DEF = 6'b000100;

  // Both timers share one width, sized for the longest programmed delay.
  function automatic int timer_w(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/alarm_down_counter.sv
// Loadable down counter that saturates at zero; zero flag comes straight off the register.
// Latency: load/decrement take effect at the next clk edge.
// Backpressure: none.
module alarm_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/alarm_arm_controller.sv
// Alarm arming FSM: code arm/disarm, exit/entry delays, latched alarm with timed siren, lockout.
// Latency: an input sampled at a clk edge updates state and all outputs at that same edge.
// Backpressure: none; codes presented while locked are dropped.
module alarm_arm_controller
  import alarm_pkg::*;
#(
  parameter logic [CODE_W-1:0] ARM_CODE    = ARM_CODE_DEF,
  parameter logic [CODE_W-1:0] DISARM_CODE = DISARM_CODE_DEF,
  parameter int                EXIT_CYC    = 16,
  parameter int                ENTRY_CYC   = 8,
  parameter int                SIREN_CYC   = 32,
  parameter int                MAX_FAIL    = 3,
  parameter int                LOCK_CYC    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code,
  input  logic              code_vld,
  input  logic              motion1,
  input  logic              motion2,
  input  logic              reed,
  output logic              active,
  output logic              alarm,
  output logic              siren,
  output logic              locked,
  output logic [2:0]        state
);

  localparam int TW = timer_w(EXIT_CYC, ENTRY_CYC, SIREN_CYC, LOCK_CYC);
  localparam int FW = $clog2(MAX_FAIL + 1);

  state_t          st_q;
  state_t          nxt;
  logic [FW-1:0]   fail_cnt;
  logic            good;
  logic            bad;
  logic            lock_now;
  logic            motion_pair;
  logic            st_load;
  logic            st_dec;
  logic [TW-1:0]   st_load_val;
  logic            st_zero;
  logic            lk_zero;

  always_comb begin
    good        = code_vld && !locked &&
                  (code == ((st_q == DISARMED) ? ARM_CODE : DISARM_CODE));
    bad         = code_vld && !locked && !good;
    lock_now    = bad && (fail_cnt == FW'(MAX_FAIL - 1));
    motion_pair = motion1 && motion2;
  end

  always_comb begin
    nxt = st_q;
    case (st_q)
      DISARMED:    if (good) nxt = EXIT_DELAY;
      EXIT_DELAY:  if (good) nxt = DISARMED;
                   else if (st_zero) nxt = ARMED;
      ARMED:       if (good) nxt = DISARMED;
                   else if (lock_now || motion_pair) nxt = ALARM;
                   else if (reed) nxt = ENTRY_DELAY;
      ENTRY_DELAY: if (good) nxt = DISARMED;
                   else if (lock_now || motion_pair || st_zero) nxt = ALARM;
      ALARM:       if (good) nxt = DISARMED;
      default:     nxt = DISARMED;
    endcase
  end

  // The state timer reloads on entry to any timed state and counts down while the state holds.
  always_comb begin
    st_load_val = '0;
    case (nxt)
      EXIT_DELAY:  st_load_val = TW'(EXIT_CYC - 1);
      ENTRY_DELAY: st_load_val = TW'(ENTRY_CYC - 1);
      ALARM:       st_load_val = TW'(SIREN_CYC - 1);
      default:     st_load_val = '0;
    endcase
    st_load = (nxt != st_q) &&
              ((nxt == EXIT_DELAY) || (nxt == ENTRY_DELAY) || (nxt == ALARM));
    st_dec  = (nxt == st_q);
  end

  alarm_down_counter #(.W(TW)) u_state_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (st_load),
    .load_val (st_load_val),
    .dec      (st_dec),
    .zero     (st_zero)
  );

  alarm_down_counter #(.W(TW)) u_lock_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lock_now),
    .load_val (TW'(LOCK_CYC - 1)),
    .dec      (locked),
    .zero     (lk_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= DISARMED;
      active   <= 1'b0;
      alarm    <= 1'b0;
      siren    <= 1'b0;
      locked   <= 1'b0;
      fail_cnt <= '0;
    end else begin
      st_q   <= nxt;
      active <= (nxt != DISARMED);
      alarm  <= (nxt == ALARM);

      // Siren starts on ALARM entry and stops once the siren timer has run out.
      if (nxt != ALARM)        siren <= 1'b0;
      else if (st_q != ALARM)  siren <= 1'b1;
      else if (st_zero)        siren <= 1'b0;

      if (good)                fail_cnt <= '0;
      else if (lock_now)       fail_cnt <= '0;
      else if (bad)            fail_cnt <= fail_cnt + 1'b1;

      if (lock_now)            locked <= 1'b1;
      else if (lk_zero)        locked <= 1'b0;
    end
  end

  assign state = st_q;

endmodule
